joystick_nav_decoder: RTL
=========================

# joystick_nav_decoder

Parametrised converter from N analog joystick axes (ADC samples) to debounced navigation pulses, with per-axis independent FSMs, dead-zone hysteresis, hold qualification and optional auto-repeat (typematic) while a direction is held. Sits between the ADC sampling front end and the LCD menu controller. It replaces the fixed 2-axis, single-shot joystick-to-button converter. Axis 0 = X (neg = Left, pos = Right); axis 1 = Y (neg = Down, pos = Up).

## Interface
- N_AXES, 2, number of independent axes
- ADC_W, 10, sample width per axis (unsigned)
- DZ_LOW, 400, lower dead-zone bound (exit when sample < DZ_LOW)
- DZ_HIGH, 600, upper dead-zone bound (exit when sample > DZ_HIGH)
- HYST, 16, re-entry hysteresis; re-centre only when DZ_LOW+HYST <= sample <= DZ_HIGH-HYST
- HOLD_CYCLES, 5000, qualification cycles before first pulse (>= 1)
- REPEAT_DELAY, 500000, cycles after first pulse before auto-repeat starts
- REPEAT_PERIOD, 100000, cycles between repeat pulses (>= 1)
- CNT_W, 20, counter width; must hold max(HOLD_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- axis_in  in  N_AXES*ADC_W  axis samples, axis i at [i*ADC_W +: ADC_W]; already synchronous to clk
- repeat_en  in  1  enables auto-repeat for all axes
- pulse_neg  out  N_AXES  one-cycle pulse, negative direction
- pulse_pos  out  N_AXES  one-cycle pulse, positive direction
- held_neg  out  N_AXES  level: axis qualified and held negative (FIRE/REPEAT)
- held_pos  out  N_AXES  level: axis qualified and held positive (FIRE/REPEAT)

## Operation
- Per-axis classification: NEG if sample < DZ_LOW, POS if sample > DZ_HIGH, CENTRE if inside the hysteresis window, otherwise BAND (hysteresis band, no state change).
- States per axis: IDLE, HOLD, FIRE, REPEAT. Per axis: latched direction dir (NEG/POS) and counter cnt.
- IDLE: NEG/POS -> HOLD, dir latched, cnt=0. CENTRE/BAND -> stay.
- HOLD: CENTRE -> IDLE. Opposite direction -> stay HOLD, dir flipped, cnt=0. Same dir or BAND: when cnt==HOLD_CYCLES -> pulse dir, FIRE, cnt=0; else cnt+1.
- FIRE: CENTRE -> IDLE. Opposite direction -> HOLD, dir flipped, cnt=0, no pulse. repeat_en=0 -> cnt held at 0, no pulses. repeat_en=1: when cnt==REPEAT_DELAY -> pulse dir, REPEAT, cnt=0; else cnt+1.
- REPEAT: CENTRE -> IDLE. Opposite direction -> HOLD as above. repeat_en=0 -> FIRE, cnt=0. Otherwise when cnt==REPEAT_PERIOD -> pulse dir, cnt=0; else cnt+1.
- CENTRE takes priority over all counter events in the same cycle; a direction flip takes priority over pulse generation.
- pulse_neg[i] and pulse_pos[i] are never high together; axes never influence each other.
- held_* derives from the registered state and dir only.
- Parameter legality (elaboration check): DZ_LOW+HYST <= DZ_HIGH-HYST; DZ_HIGH < 2**ADC_W; counts < 2**CNT_W.

## Timing
- Reset: all outputs 0, all axes IDLE, cnt=0, dir=NEG. Asynchronous assertion mid-operation aborts any hold/repeat immediately; no pulse is emitted on release.
- Outputs are registered. Pulses are exactly one clk wide.
- Constant deflection first sampled at edge E0: first pulse high in the cycle after edge E0+HOLD_CYCLES+1. held_* rises with that pulse.
- With repeat_en=1: second pulse REPEAT_DELAY+1 cycles after the first; subsequent pulses every REPEAT_PERIOD+1 cycles.
- A CENTRE sample at edge Ec clears held_* after Ec; no pulse after Ec.

## Structure
- Package joystick_nav_pkg: state enum (IDLE/HOLD/FIRE/REPEAT), direction enum, default threshold and count constants.
- Sub-module joystick_axis_fsm: one axis (classifier, FSM, counter, registered outputs). Instantiated N_AXES times by generate in the top. The top only slices buses and fans out repeat_en.

## Test plan
Bench parameters: HOLD_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, HYST=16.
- Reset mid-HOLD: axis0=100 for 3 cycles, then rst_n low -> all outputs 0. After release with axis0=512 -> no pulse.
- Single shot: axis0=100 held, repeat_en=0 -> exactly one pulse_neg[0], at E0+5. held_neg[0]=1 until axis0=512. pulse_pos[0]=0 throughout.
- Glitch reject: axis1=900 for 3 cycles, then 512 -> no pulse. Axis1 in hysteresis band (590) after qualification -> held_pos[1] stays 1. 580 -> held_pos[1] clears.
- Auto-repeat: axis1=900, repeat_en=1 for 40 cycles -> pulse_pos[1] at E0+5, +11, then every 4 cycles. Dropping repeat_en stops pulses; held_pos[1] stays 1.
- Reversal: axis0 qualified at 100, then 900 -> no pulse at the flip. pulse_pos[0] fires 5 cycles after the flip, and held_neg[0] falls at the flip.
- Independence: axis0=100 and axis1=900 simultaneously -> pulse_neg[0] and pulse_pos[1] fire in the same cycle. Axis1 is unaffected by axis0 activity.

Source files
------------

// File: rtl/joystick_nav_pkg.sv
// Shared types and default constants for the joystick navigation decoder.
package joystick_nav_pkg;

    // Per-axis controller state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FIRE   = 2'd2,
        ST_REPEAT = 2'd3
    } axis_state_t;

    // Latched deflection direction
    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } axis_dir_t;

    // Sample classification against the dead zone and its hysteresis window
    typedef enum logic [1:0] {
        CLS_CENTRE = 2'd0,
        CLS_BAND   = 2'd1,
        CLS_NEG    = 2'd2,
        CLS_POS    = 2'd3
    } axis_class_t;

    localparam int unsigned DEF_N_AXES        = 2;
    localparam int unsigned DEF_ADC_W         = 10;
    localparam int unsigned DEF_DZ_LOW        = 400;
    localparam int unsigned DEF_DZ_HIGH       = 600;
    localparam int unsigned DEF_HYST          = 16;
    localparam int unsigned DEF_HOLD_CYCLES   = 5000;
    localparam int unsigned DEF_REPEAT_DELAY  = 500000;
    localparam int unsigned DEF_REPEAT_PERIOD = 100000;
    localparam int unsigned DEF_CNT_W         = 20;

    // Classify a sample: outside the dead zone is a direction, inside the
    // shrunken window is centre, anything in between is the hysteresis band.
    function automatic axis_class_t classify_sample(
        input int unsigned sample,
        input int unsigned dz_low,
        input int unsigned dz_high,
        input int unsigned hyst
    );
        axis_class_t cls;
        if (sample < dz_low) begin
            cls = CLS_NEG;
        end else if (sample > dz_high) begin
            cls = CLS_POS;
        end else if ((sample >= dz_low + hyst) && (sample + hyst <= dz_high)) begin
            cls = CLS_CENTRE;
        end else begin
            cls = CLS_BAND;
        end
        return cls;
    endfunction

endpackage

// File: rtl/joystick_axis_fsm.sv
// One joystick axis: classifier, hold/fire/repeat FSM, counter and
// registered pulse outputs.
module joystick_axis_fsm
    import joystick_nav_pkg::*;
#(
    parameter int unsigned ADC_W         = DEF_ADC_W,
    parameter int unsigned DZ_LOW        = DEF_DZ_LOW,
    parameter int unsigned DZ_HIGH       = DEF_DZ_HIGH,
    parameter int unsigned HYST          = DEF_HYST,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] i_sample,
    input  logic             i_repeat_en,
    output logic             o_pulse_neg,
    output logic             o_pulse_pos,
    output logic             o_held_neg,
    output logic             o_held_pos
);

    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_MAX  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_MAX = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam longint unsigned  CNT_LIMIT  = 64'd1 << CNT_W;

    // Reject illegal parameter sets at elaboration
    if (longint'(DZ_LOW) + 2 * longint'(HYST) > longint'(DZ_HIGH)) begin : g_err_window
        $error("joystick_axis_fsm: hysteresis window is empty");
    end
    if (longint'(DZ_HIGH) >= (64'd1 << ADC_W)) begin : g_err_dz_high
        $error("joystick_axis_fsm: DZ_HIGH does not fit in ADC_W bits");
    end
    if ((HOLD_CYCLES < 1) || (REPEAT_PERIOD < 1)) begin : g_err_min
        $error("joystick_axis_fsm: HOLD_CYCLES and REPEAT_PERIOD must be >= 1");
    end
    if ((longint'(HOLD_CYCLES) >= CNT_LIMIT) || (longint'(REPEAT_DELAY) >= CNT_LIMIT) ||
        (longint'(REPEAT_PERIOD) >= CNT_LIMIT)) begin : g_err_cnt
        $error("joystick_axis_fsm: CNT_W too narrow for the configured counts");
    end

    axis_state_t      r_state;
    axis_dir_t        r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse_neg;
    logic             r_pulse_pos;

    axis_class_t w_cls;
    logic        w_centre;
    logic        w_opposite;
    logic        w_qualified;

    assign w_cls      = classify_sample(32'(i_sample), DZ_LOW, DZ_HIGH, HYST);
    assign w_centre   = (w_cls == CLS_CENTRE);
    assign w_opposite = ((w_cls == CLS_NEG) && (r_dir == DIR_POS)) ||
                        ((w_cls == CLS_POS) && (r_dir == DIR_NEG));

    // Per-axis FSM: centre beats everything, a flip beats any pulse event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dir       <= DIR_NEG;
            r_cnt       <= '0;
            r_pulse_neg <= 1'b0;
            r_pulse_pos <= 1'b0;
        end else begin
            r_pulse_neg <= 1'b0;
            r_pulse_pos <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if ((w_cls == CLS_NEG) || (w_cls == CLS_POS)) begin
                        r_state <= ST_HOLD;
                        r_dir   <= (w_cls == CLS_POS) ? DIR_POS : DIR_NEG;
                        r_cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (w_centre) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_opposite) begin
                        r_dir <= (r_dir == DIR_NEG) ? DIR_POS : DIR_NEG;
                        r_cnt <= '0;
                    end else if (r_cnt == HOLD_MAX) begin
                        r_pulse_neg <= (r_dir == DIR_NEG);
                        r_pulse_pos <= (r_dir == DIR_POS);
                        r_state     <= ST_FIRE;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_FIRE: begin
                    if (w_centre) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_opposite) begin
                        r_state <= ST_HOLD;
                        r_dir   <= (r_dir == DIR_NEG) ? DIR_POS : DIR_NEG;
                        r_cnt   <= '0;
                    end else if (!i_repeat_en) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DELAY_MAX) begin
                        r_pulse_neg <= (r_dir == DIR_NEG);
                        r_pulse_pos <= (r_dir == DIR_POS);
                        r_state     <= ST_REPEAT;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (w_centre) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_opposite) begin
                        r_state <= ST_HOLD;
                        r_dir   <= (r_dir == DIR_NEG) ? DIR_POS : DIR_NEG;
                        r_cnt   <= '0;
                    end else if (!i_repeat_en) begin
                        r_state <= ST_FIRE;
                        r_cnt   <= '0;
                    end else if (r_cnt == PERIOD_MAX) begin
                        r_pulse_neg <= (r_dir == DIR_NEG);
                        r_pulse_pos <= (r_dir == DIR_POS);
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Held levels are a pure decode of registered state and direction
    assign w_qualified = (r_state == ST_FIRE) || (r_state == ST_REPEAT);
    assign o_held_neg  = w_qualified && (r_dir == DIR_NEG);
    assign o_held_pos  = w_qualified && (r_dir == DIR_POS);
    assign o_pulse_neg = r_pulse_neg;
    assign o_pulse_pos = r_pulse_pos;

endmodule

// File: rtl/joystick_nav_decoder.sv
// N-axis joystick to navigation pulse decoder: slices the sample bus and
// runs one independent axis controller per axis.
module joystick_nav_decoder
    import joystick_nav_pkg::*;
#(
    parameter int unsigned N_AXES        = DEF_N_AXES,
    parameter int unsigned ADC_W         = DEF_ADC_W,
    parameter int unsigned DZ_LOW        = DEF_DZ_LOW,
    parameter int unsigned DZ_HIGH       = DEF_DZ_HIGH,
    parameter int unsigned HYST          = DEF_HYST,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_AXES*ADC_W-1:0] i_axis_in,
    input  logic                    i_repeat_en,
    output logic [N_AXES-1:0]       o_pulse_neg,
    output logic [N_AXES-1:0]       o_pulse_pos,
    output logic [N_AXES-1:0]       o_held_neg,
    output logic [N_AXES-1:0]       o_held_pos
);

    // One controller per axis; axes share only clock, reset and repeat_en
    for (genvar gi = 0; gi < N_AXES; gi++) begin : g_axis
        joystick_axis_fsm #(
            .ADC_W        (ADC_W),
            .DZ_LOW       (DZ_LOW),
            .DZ_HIGH      (DZ_HIGH),
            .HYST         (HYST),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_axis (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_sample   (i_axis_in[gi*ADC_W +: ADC_W]),
            .i_repeat_en(i_repeat_en),
            .o_pulse_neg(o_pulse_neg[gi]),
            .o_pulse_pos(o_pulse_pos[gi]),
            .o_held_neg (o_held_neg[gi]),
            .o_held_pos (o_held_pos[gi])
        );
    end

endmodule
